// File: rtl/can_frame_rx.sv
// Receive side of the simplified CAN link.
// Synchronizes the bus, times bits from the SOF edge, deserializes one base frame and checks its CRC and form.
module can_frame_rx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CAN_BUS,
  output logic        RX_VALID,
  output logic [10:0] RX_MSG_ID,
  output logic [3:0]  RX_DLC,
  output logic [3:0]  RX_DATA,
  output logic        RX_CRC_ERR,
  output logic        RX_FORM_ERR,
  output logic        RX_BUSY,
  output logic [3:0]  dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SOF, S_ID, S_IDE, S_DLC, S_DATA, S_CRC, S_CRC_DEL, S_EOF, S_WAIT_IDLE
  } state_t;

  state_t        state;
  logic          sync1;
  logic          sync2;
  logic          sb_q;
  logic [CW-1:0] cnt;
  logic [3:0]    bcnt;
  logic [10:0]   id_sh;
  logic [3:0]    dlc_sh;
  logic [3:0]    data_sh;
  logic [14:0]   crc_rx;
  logic [14:0]   crc_calc;
  logic          sb;

  assign sb        = sync2;
  assign dbg_state = state;

  function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
    logic n;
    n = b ^ c[14];
    return {c[13:0], 1'b0} ^ (n ? 15'h4599 : 15'h0000);
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      sb_q        <= 1'b1;
      state       <= S_IDLE;
      cnt         <= '0;
      bcnt        <= '0;
      id_sh       <= '0;
      dlc_sh      <= '0;
      data_sh     <= '0;
      crc_rx      <= '0;
      crc_calc    <= '0;
      RX_VALID    <= 1'b0;
      RX_MSG_ID   <= '0;
      RX_DLC      <= '0;
      RX_DATA     <= '0;
      RX_CRC_ERR  <= 1'b0;
      RX_FORM_ERR <= 1'b0;
      RX_BUSY     <= 1'b0;
    end else begin
      sync1       <= CAN_BUS;
      sync2       <= sync1;
      sb_q        <= sync2;
      RX_VALID    <= 1'b0;
      RX_CRC_ERR  <= 1'b0;
      RX_FORM_ERR <= 1'b0;

      if (state == S_IDLE) begin
        if (sb_q && !sb) begin
          state    <= S_SOF;
          cnt      <= HALF_M1;
          crc_calc <= '0;
          RX_BUSY  <= 1'b1;
        end
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end else begin
        // Sample point: the bit grid is fixed by the SOF edge for the whole frame.
        cnt <= FULL_M1;
        case (state)
          S_SOF: begin
            if (sb) begin
              state   <= S_IDLE;
              RX_BUSY <= 1'b0;
            end else begin
              crc_calc <= crc_step(crc_calc, sb);
              bcnt     <= 4'd10;
              state    <= S_ID;
            end
          end
          S_ID: begin
            id_sh    <= {id_sh[9:0], sb};
            crc_calc <= crc_step(crc_calc, sb);
            if (bcnt == 4'd0) state <= S_IDE;
            else              bcnt  <= bcnt - 4'd1;
          end
          S_IDE: begin
            crc_calc <= crc_step(crc_calc, sb);
            if (sb) begin
              RX_FORM_ERR <= 1'b1;
              bcnt        <= 4'd0;
              state       <= S_WAIT_IDLE;
            end else begin
              bcnt  <= 4'd3;
              state <= S_DLC;
            end
          end
          S_DLC: begin
            dlc_sh   <= {dlc_sh[2:0], sb};
            crc_calc <= crc_step(crc_calc, sb);
            if (bcnt == 4'd0) begin
              bcnt  <= 4'd3;
              state <= S_DATA;
            end else begin
              bcnt <= bcnt - 4'd1;
            end
          end
          S_DATA: begin
            data_sh  <= {data_sh[2:0], sb};
            crc_calc <= crc_step(crc_calc, sb);
            if (bcnt == 4'd0) begin
              bcnt  <= 4'd14;
              state <= S_CRC;
            end else begin
              bcnt <= bcnt - 4'd1;
            end
          end
          S_CRC: begin
            crc_rx <= {crc_rx[13:0], sb};
            if (bcnt == 4'd0) state <= S_CRC_DEL;
            else              bcnt  <= bcnt - 4'd1;
          end
          S_CRC_DEL: begin
            // CRC mismatch takes priority over a bad delimiter.
            if (crc_rx != crc_calc) begin
              RX_CRC_ERR <= 1'b1;
              bcnt       <= 4'd0;
              state      <= S_WAIT_IDLE;
            end else if (!sb) begin
              RX_FORM_ERR <= 1'b1;
              bcnt        <= 4'd0;
              state       <= S_WAIT_IDLE;
            end else begin
              bcnt  <= 4'd6;
              state <= S_EOF;
            end
          end
          S_EOF: begin
            if (!sb) begin
              RX_FORM_ERR <= 1'b1;
              bcnt        <= 4'd0;
              state       <= S_WAIT_IDLE;
            end else if (bcnt == 4'd0) begin
              RX_VALID  <= 1'b1;
              RX_MSG_ID <= id_sh;
              RX_DLC    <= dlc_sh;
              RX_DATA   <= data_sh;
              RX_BUSY   <= 1'b0;
              state     <= S_IDLE;
            end else begin
              bcnt <= bcnt - 4'd1;
            end
          end
          S_WAIT_IDLE: begin
            // bcnt counts consecutive recessive samples here.
            if (!sb) begin
              bcnt <= 4'd0;
            end else if (bcnt == 4'd6) begin
              RX_BUSY <= 1'b0;
              state   <= S_IDLE;
            end else begin
              bcnt <= bcnt + 4'd1;
            end
          end
          default: begin
            RX_BUSY <= 1'b0;
            state   <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
